// File: rtl/ipf_out_writer_if.sv
// Pixel-stream and memory-write bundle between the filter, the out-writer and the result memory.
// The master drives the filter stream and mem_ready; the slave is the out-writer.
interface ipf_out_writer_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          out_en;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_addr;
    logic          finish;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;

    modport master (
        output out_en, dout, dout_addr, finish, mem_ready,
        input  mem_req, mem_addr, mem_wdata
    );

    modport slave (
        input  out_en, dout, dout_addr, finish, mem_ready,
        output mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ipf_out_writer.sv
// Buffers the filter's un-stallable pixel stream in a small FIFO and writes it to the
// result memory over a valid/ready handshake; flags drops and signals done after finish.
module ipf_out_writer #(
    parameter int DEPTH = 8,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    ipf_out_writer_if.slave     bus,
    output logic                almost_full,
    output logic                overflow,
    output logic [14:0]         pix_cnt,
    output logic                done
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + DW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   fifo_q [DEPTH];
    logic [EW-1:0]   fifo_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [EW-1:0]   head_q, head_d;
    logic            almost_full_q, almost_full_d;
    logic            overflow_q, overflow_d;
    logic [14:0]     pix_cnt_q, pix_cnt_d;

    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            drop;
    logic [PW:0]     remaining;
    logic [EW-1:0]   entry;

    assign bus.mem_req   = (count_q != '0);
    assign bus.mem_addr  = head_q[EW-1:DW];
    assign bus.mem_wdata = head_q[DW-1:0];
    assign almost_full   = almost_full_q;
    assign overflow      = overflow_q;
    assign pix_cnt       = pix_cnt_q;
    assign done          = (state_q == DONE);

    always_comb begin
        entry     = {bus.dout_addr, bus.dout};
        push_req  = bus.out_en && !bus.finish && ((state_q == IDLE) || (state_q == RUN));
        pop       = bus.mem_req && bus.mem_ready;
        full      = (count_q == (PW+1)'(DEPTH));
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;

        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = entry;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head is registered so the bus holds its last value once the FIFO drains.
        remaining = pop ? (count_q - 1'b1) : count_q;
        head_d    = head_q;
        if (remaining != '0) begin
            head_d = fifo_q[rd_ptr_d];
        end else if (push) begin
            head_d = entry;
        end

        almost_full_d = (count_d >= (PW+1)'(DEPTH - 2));
        overflow_d    = overflow_q | drop;
        pix_cnt_d     = pix_cnt_q;
        if (pop && (pix_cnt_q != 15'h7FFF)) begin
            pix_cnt_d = pix_cnt_q + 15'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.finish) begin
                    state_d = DRAIN;
                end else if (push) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.finish) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_q        <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            pix_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            head_q        <= head_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            pix_cnt_q     <= pix_cnt_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_ipf_out_writer.sv
// Randomized and directed bench for ipf_out_writer with a queue-based reference model
// and a negedge monitor that scores every memory write against the expected stream.
module tb_ipf_out_writer;
    localparam int DEPTH = 8;
    localparam int AW    = 14;
    localparam int DW    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        almost_full;
    logic        overflow;
    logic [14:0] pix_cnt;
    logic        done;

    ipf_out_writer_if #(.AW(AW), .DW(DW)) bus ();

    ipf_out_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .almost_full (almost_full),
        .overflow    (overflow),
        .pix_cnt     (pix_cnt),
        .done        (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model: occupancy, flags and the ordered list of writes still owed.
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] last_head;
    int m_count;
    int m_pix;
    bit m_ovf;
    bit m_drain;
    bit m_done;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyReset();
        reset         = 1'b1;
        bus.out_en    = 1'b0;
        bus.dout      = '0;
        bus.dout_addr = '0;
        bus.finish    = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        m_count   = 0;
        m_pix     = 0;
        m_ovf     = 1'b0;
        m_drain   = 1'b0;
        m_done    = 1'b0;
        last_head = '0;
        exp_q.delete();
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic en, input logic [DW-1:0] d, input logic [AW-1:0] a,
                                 input logic fin, input logic rdy);
        bit pop;
        bit acc;
        bit drained;
        bus.out_en    = en;
        bus.dout      = d;
        bus.dout_addr = a;
        bus.finish    = fin;
        bus.mem_ready = rdy;
        pop     = (m_count > 0) && rdy;
        acc     = en && !fin && !m_drain && !m_done;
        drained = m_drain && (m_count == 0);
        @(posedge clk);
        if (acc) begin
            if ((m_count < DEPTH) || pop) begin
                exp_q.push_back({a, d});
                m_count++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) begin
            m_count--;
            if (m_pix < 32767) m_pix++;
        end
        if (drained) m_done = 1'b1;
        if (fin) m_drain = 1'b1;
        #1;
    endtask

    task automatic idleCycles(input int n, input logic fin, input logic rdy);
        for (int k = 0; k < n; k++) begin
            applyStimulus(fin, 8'hFF, '1, fin, rdy);
        end
    endtask

    task automatic pushRandom(input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, DW'($urandom), AW'($urandom), 1'b0, rdy);
        end
    endtask

    // Monitor: compares flags with the model and scores the head against the owed writes.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("mem_req", {31'd0, bus.mem_req}, {31'd0, m_count != 0});
            checkOutput("almost_full", {31'd0, almost_full}, {31'd0, m_count >= DEPTH - 2});
            checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            checkOutput("pix_cnt", {17'd0, pix_cnt}, 32'(m_pix));
            checkOutput("done", {31'd0, done}, {31'd0, m_done});
            if (bus.mem_req) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no request",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    checkOutput("head", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_q[0]));
                    if (bus.mem_ready) last_head = exp_q.pop_front();
                end
            end else begin
                checkOutput("idle_head", 32'({bus.mem_addr, bus.mem_wdata}), 32'(last_head));
            end
        end
    end

    initial begin
        applyReset();
        mon_en = 1'b1;
        checkOutput("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset_pix_cnt", {17'd0, pix_cnt}, 32'd0);

        // Streaming at full rate, then finish with out_en still high.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            lo = i[7:0];
            applyStimulus(1'b1, lo ^ 8'h5A, AW'(i), 1'b0, 1'b1);
            checkOutput("stream_latency", {31'd0, bus.mem_req}, 32'd1);
        end
        idleCycles(6, 1'b1, 1'b1);
        checkOutput("stream_pix_cnt", {17'd0, pix_cnt}, 32'd256);
        checkOutput("stream_done", {31'd0, done}, 32'd1);
        checkOutput("stream_overflow", {31'd0, overflow}, 32'd0);

        // Stall absorb.
        applyReset();
        pushRandom(6, 1'b0);
        checkOutput("stall_almost_full", {31'd0, almost_full}, 32'd1);
        idleCycles(8, 1'b0, 1'b1);
        checkOutput("stall_pix_cnt", {17'd0, pix_cnt}, 32'd6);
        checkOutput("stall_overflow", {31'd0, overflow}, 32'd0);

        // Overflow.
        applyReset();
        pushRandom(10, 1'b0);
        checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
        idleCycles(12, 1'b0, 1'b1);
        checkOutput("ovf_pix_cnt", {17'd0, pix_cnt}, 32'd8);
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO with simultaneous push and pop.
        applyReset();
        pushRandom(8, 1'b0);
        pushRandom(1, 1'b1);
        checkOutput("fullpop_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("fullpop_almost_full", {31'd0, almost_full}, 32'd1);
        idleCycles(10, 1'b0, 1'b1);
        checkOutput("fullpop_pix_cnt", {17'd0, pix_cnt}, 32'd9);

        // Finish with entries pending; 8'hFF samples must never be written.
        applyReset();
        pushRandom(3, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'hFF, '1, 1'b1, 1'b1);
        checkOutput("finish_not_done_yet", {31'd0, done}, 32'd0);
        applyStimulus(1'b1, 8'hFF, '1, 1'b1, 1'b1);
        checkOutput("finish_done", {31'd0, done}, 32'd1);
        checkOutput("finish_pix_cnt", {17'd0, pix_cnt}, 32'd3);

        // Reset in the middle of a stall.
        applyReset();
        pushRandom(4, 1'b0);
        applyReset();
        checkOutput("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("midrst_pix_cnt", {17'd0, pix_cnt}, 32'd0);
        checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("midrst_mem_addr", {18'd0, bus.mem_addr}, 32'd0);
        idleCycles(6, 1'b0, 1'b1);
        checkOutput("midrst_no_stale", {17'd0, pix_cnt}, 32'd0);

        // Randomized traffic with varying back-pressure, then finish and drain.
        applyReset();
        for (int i = 0; i < 600; i++) begin
            logic en;
            logic rdy;
            en  = ($urandom_range(0, 3) != 0);
            rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(en, DW'($urandom), AW'($urandom), 1'b0, rdy);
        end
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 8'hFF, '1, 1'b1, 1'b1);
        checkOutput("random_done", {31'd0, done}, 32'd1);

        @(posedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ipf_out_writer.md
# ipf_out_writer

Downstream stage of the image processing filter. Captures the filter's output pixel stream (`out_en`, `dout`, `dout_addr`) into a small FIFO and writes each pixel to the result image memory through a valid/ready handshake. The filter cannot be back-pressured, so the FIFO absorbs memory stalls and reports overflow. The block signals `done` once the filter raises `finish` and every accepted pixel has been written.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `AW`, 14: address width, `{lcu_y[2:0], row[3:0], lcu_x[2:0], col[3:0]}`.
- `DW`, 8: pixel width.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  **synchronous, active-high** reset (already decided; one clock domain).
- `out_en`  in  1  filter pixel valid.
- `dout`  in  DW  filter pixel.
- `dout_addr`  in  AW  filter pixel address.
- `finish`  in  1  filter end-of-image; level, stays high once set.
- `mem_req`  out  1  write request valid.
- `mem_addr`  out  AW  write address (FIFO head).
- `mem_wdata`  out  DW  write data (FIFO head).
- `mem_ready`  in  1  memory accepts the write this cycle.
- `almost_full`  out  1  FIFO count ≥ DEPTH−2.
- `overflow`  out  1  sticky: a pixel was dropped.
- `pix_cnt`  out  15  completed memory writes; saturates at 32767.
- `done`  out  1  all pixels written after `finish`; held until reset.

## Operation
- **FIFO:** register array, read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Push:** occurs when `out_en & !finish` and the state is not DONE. The entry is `{dout_addr, dout}`. Samples presented while `finish=1` are ignored, because the filter holds `out_en` high in its finish state.
- **Pop:** occurs when `mem_req & mem_ready`.
- **Push on a full FIFO:**
  - If a pop happens in the same cycle, the push is accepted and the count is unchanged.
  - Otherwise the sample is dropped, the FIFO is not modified, and `overflow` is set to 1.
- **Empty FIFO:** `mem_req=0`. `mem_addr` and `mem_wdata` hold their last value (0 after reset).
- **Push and pop in the same cycle:** both take effect and the count is unchanged.
- **Handshake:**
  - `mem_req = (count != 0)`.
  - `mem_addr` and `mem_wdata` equal the head entry.
  - While `mem_req=1` and `mem_ready=0`, `mem_addr` and `mem_wdata` must stay stable.
  - `mem_req` never deasserts without a completed transfer, except on reset.
- **pix_cnt:** +1 per pop, saturating at 32767.
- **FSM** (state register, reset → IDLE):
  - IDLE: first push → RUN. If `finish` is seen in IDLE → DRAIN.
  - RUN: `finish=1` → DRAIN. Pushes continue until that edge.
  - DRAIN: no pushes. `count==0`, with no pop in progress → DONE.
  - DONE: `done=1`, no pushes, terminal until reset.
- **Address:** passed through unchanged. No range or ordering checks.

## Timing
- **Reset values:**
  - Outputs: `mem_req=0`, `mem_addr=0`, `mem_wdata=0`, `almost_full=0`, `overflow=0`, `pix_cnt=0`, `done=0`.
  - Internal: FIFO pointers and count 0, state IDLE.
- **Reset mid-operation:** on the first edge with `reset=1`, all state and outputs return to their reset values and any outstanding request is abandoned.
- **Latency:** a sample pushed at edge N gives `mem_req=1` with that entry after edge N (visible in cycle N+1), if the FIFO was empty. If `mem_ready=1` in that cycle, it pops at edge N+1.
- **Throughput:** 1 pixel/cycle sustained with `mem_ready` held high. The FIFO never exceeds 1 entry in that case.
- **almost_full** and **overflow** are registered and update on the same edge as the count change.
- **done** rises on the edge after the final pop while in DRAIN. If the FIFO is already empty when `finish` rises, `done` rises 2 edges after `finish` is sampled high (→DRAIN, →DONE).

## Test plan
- **Streaming:** `mem_ready=1`, 256 pixels with addr 0..255 and data = addr^8'h5A, then `finish`. Required: writes in identical order; each `mem_req` appears 1 cycle after its `out_en`; `pix_cnt=256`; `done=1`; `overflow=0`.
- **Stall absorb:** `mem_ready=0` while 6 pixels are pushed (DEPTH=8), then `mem_ready=1`. Required: `almost_full=1` after the 6th push; all 6 written in order; `overflow=0`; `mem_addr`/`mem_wdata` stable throughout the stall.
- **Overflow:** `mem_ready=0`, 10 pushes. Required: first 8 retained; pushes 9–10 dropped; `overflow=1` sticky; after release exactly 8 writes, `pix_cnt=8`.
- **Full with simultaneous pop:** FIFO full, `mem_ready=1` and `out_en=1` in the same cycle. Required: the push is accepted, count stays 8, `overflow=0`.
- **Finish handling:** `finish` raised with 3 entries pending, `out_en` held at 1 with data 8'hFF. Required: the 3 entries are written, no 8'hFF write occurs, and `done=1` on the edge after the last pop.
- **Reset mid-stall:** 4 entries pending with `mem_ready=0`, then `reset=1` for 1 cycle. Required: the next cycle shows `mem_req=0`, `pix_cnt=0`, `overflow=0`, state IDLE, and no stale write appears afterward.
